button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 134 +++++++++++++
 tb/tb_button_debouncer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: two-flop synchronizer, four-state debounce FSM, registered level and pulses.
// Define DEBOUNCE_FALL_PULSE_EN to add the btn_fall pulse output.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic a_reset,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_rise
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    output logic btn_fall
`endif
);

    localparam int unsigned CntW =
        ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLow,
        StWaitHigh,
        StStableHigh,
        StWaitLow
    } state_e;

    logic            sync1_q, sync2_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level;
    logic            btn_out_q, btn_rise_q;

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A wait state falls back to its stable state on any opposite sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StStableLow: begin
                if (sync2_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitHigh: begin
                if (!sync2_q) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStableHigh: begin
                if (!sync2_q) begin
                    state_d = StWaitLow;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitLow: begin
                if (sync2_q) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StStableLow;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == StStableHigh) || (state_q == StWaitLow);

    // Pulses are derived from the level register so they coincide with the btn_out edge.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            btn_out_q  <= 1'b0;
            btn_rise_q <= 1'b0;
        end else begin
            btn_out_q  <= level;
            btn_rise_q <= level & ~btn_out_q;
        end
    end

    assign btn_out  = btn_out_q;
    assign btn_rise = btn_rise_q;

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic btn_fall_q;

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            btn_fall_q <= 1'b0;
        end else begin
            btn_fall_q <= ~level & btn_out_q;
        end
    end

    assign btn_fall = btn_fall_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected btn_out edges with their
// cycle numbers, a negedge monitor pops and checks them whenever the DUT shows an edge or pulse.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic a_reset;
    logic btn_in;
    logic btn_out;
    logic btn_rise;
    logic fall_w;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FallEn = 1'b1;
    logic btn_fall;
    assign fall_w = btn_fall;
`else
    localparam bit FallEn = 1'b0;
    assign fall_w = 1'b0;
`endif

    button_debouncer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .a_reset (a_reset),
        .btn_in  (btn_in),
        .btn_out (btn_out),
        .btn_rise(btn_rise)
`ifdef DEBOUNCE_FALL_PULSE_EN
        ,
        .btn_fall(btn_fall)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        bit rise;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_out = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any btn_out edge or pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t ev;
        if (!a_reset) begin
            if (btn_out != prev_out || btn_rise || fall_w) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d out=%b rise=%b fall=%b, required no event",
                             cyc, btn_out, btn_rise, fall_w);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc != ev.cyc || btn_out != ev.rise || btn_rise != ev.rise ||
                        fall_w != (FallEn && !ev.rise)) begin
                        errors++;
                        $display("FAIL %s_event got cyc=%0d out=%b rise=%b fall=%b, required cyc=%0d out=%b rise=%b fall=%b",
                                 ev.rise ? "rise" : "fall", cyc, btn_out, btn_rise, fall_w,
                                 ev.cyc, ev.rise, ev.rise, FallEn && !ev.rise);
                    end
                end
            end
            if (btn_rise && fall_w) begin
                checks++;
                errors++;
                $display("FAIL both_pulses cyc=%0d rise=1 fall=1, required not both", cyc);
            end
        end
        prev_out = btn_out;
    end

    task automatic check_zero(input string name);
        checks++;
        if (btn_out || btn_rise || fall_w) begin
            errors++;
            $display("FAIL %s got out=%b rise=%b fall=%b, required all 0",
                     name, btn_out, btn_rise, fall_w);
        end
    endtask

    task automatic check_level(input string name, input logic exp);
        @(negedge clk);
        checks++;
        if (btn_out !== exp) begin
            errors++;
            $display("FAIL %s got btn_out=%b, required %b", name, btn_out, exp);
        end
    endtask

    // Drive on a negedge; the following posedge is the first sampling edge.
    task automatic drive(input logic v);
        @(negedge clk);
        btn_in = v;
    endtask

    task automatic push(input bit rise, input int cyc_exp);
        exp_t e;
        e.rise = rise;
        e.cyc  = cyc_exp;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_reset = 1'b1;
        btn_in  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #7 btn_in = ~btn_in;
            #2 check_zero("reset_hold");
            #1;
        end
        btn_in  = 1'b0;
        a_reset = 1'b0;
        wait_cycles(5);
        check_level("idle_low", 1'b0);

        // Clean rise, then clean fall: edge 6 edges after first sampling edge.
        drive(1'b1);
        push(1'b1, cyc + 7);
        wait_cycles(10);
        check_level("held_high", 1'b1);
        drive(1'b0);
        push(1'b0, cyc + 7);
        wait_cycles(10);
        check_level("held_low", 1'b0);

        // Three-cycle highs (one short of the threshold) are rejected.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1);
            wait_cycles(2);
            drive(1'b0);
        end
        wait_cycles(8);
        check_level("bounce_low_rejected", 1'b0);

        // Exactly four cycles high is accepted, and the following low is too.
        drive(1'b1);
        push(1'b1, cyc + 7);
        push(1'b0, cyc + 11);
        wait_cycles(3);
        drive(1'b0);
        wait_cycles(12);
        check_level("exact_threshold", 1'b0);

        // Short lows while stable high are rejected.
        drive(1'b1);
        push(1'b1, cyc + 7);
        wait_cycles(10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0);
            wait_cycles(2);
            drive(1'b1);
        end
        wait_cycles(8);
        check_level("bounce_high_rejected", 1'b1);
        drive(1'b0);
        push(1'b0, cyc + 7);
        wait_cycles(10);
        check_level("low_again", 1'b0);

        // Unaligned reset pulse during WAIT_HIGH aborts the count; restart from release.
        drive(1'b1);
        wait_cycles(3);
        #5 a_reset = 1'b1;
        #1 check_zero("reset_mid_wait");
        #9 a_reset = 1'b0;
        push(1'b1, cyc + 7);
        wait_cycles(10);
        check_level("rise_after_reset", 1'b1);
        drive(1'b0);
        push(1'b0, cyc + 7);
        wait_cycles(10);
        check_level("final_low", 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d pending, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
